switch_conf_ctrl: RTL and testbench
===================================

SWITCH_CONF_CTRL -- requirements
Module: switch_conf_ctrl

Interface
- REQ-001: Parameter NUM_SW, default 4, number of switches configured by this controller.
- REQ-002: Parameter CONF_BITS, default 48, configuration bits per switch.
- REQ-003: Parameter WORD_W, default 16, width of one configuration word; CONF_BITS SHALL be an integer multiple of WORD_W.
- REQ-004: Derived WPS = CONF_BITS/WORD_W words per switch (3 at defaults); TOTAL = NUM_SW*WPS.
- REQ-005: clk  input  1  sole clock; all state SHALL update on its rising edge.
- REQ-006: rst_n  input  1  reset, asynchronous, active-low.
- REQ-007: start  input  1  single-cycle request to begin a configuration load.
- REQ-008: abort  input  1  cancel an in-progress load.
- REQ-009: in_valid  input  1  config word present on in_data.
- REQ-010: in_data  input  WORD_W  config word.
- REQ-011: in_ready  output  1  controller accepts in_data this cycle.
- REQ-012: fabric_idle  input  1  fabric has no tokens in flight.
- REQ-013: fabric_hold  output  1  request fabric to stop injecting data.
- REQ-014: conf_out  output  NUM_SW*CONF_BITS  active configuration; switch k owns bits [k*CONF_BITS +: CONF_BITS].
- REQ-015: conf_en  output  1  one-cycle pulse, new conf_out valid.
- REQ-016: done  output  1  one-cycle pulse, load committed.
- REQ-017: busy  output  1  high in any state other than IDLE.

Function
- REQ-018: FSM states SHALL be IDLE, LOAD, HOLD, COMMIT.
- REQ-019: IDLE -> LOAD on start=1 and abort=0; start in any other state SHALL be ignored.
- REQ-020: in_ready SHALL be 1 only in LOAD; a word is accepted when in_valid & in_ready.
- REQ-021: Accepted word n (0..TOTAL-1) SHALL be written to shadow bits [n*WORD_W +: WORD_W]; word counter increments by 1 per accept, no wrap within a load.
- REQ-022: Order SHALL be switch 0 word 0 (bits [15:0]), word 1 ([31:16]), word 2 ([47:32]), then switch 1, etc.
- REQ-023: LOAD -> HOLD on the cycle the word with n=TOTAL-1 is accepted; in_ready SHALL be 0 the next cycle.
- REQ-024: fabric_hold SHALL be 1 in HOLD and COMMIT, 0 otherwise.
- REQ-025: In HOLD, when fabric_idle=1 is sampled, shadow SHALL be copied to conf_out at that edge and state -> COMMIT; otherwise remain in HOLD indefinitely.
- REQ-026: conf_en and done SHALL be 1 exactly in the single COMMIT cycle; COMMIT -> IDLE unconditionally.
- REQ-027: conf_out SHALL change only at the HOLD->COMMIT edge or reset; all words land atomically.
- REQ-028: abort=1 in LOAD or HOLD SHALL return to IDLE next edge, clear word counter, leave conf_out unchanged; a word accepted in the same cycle is discarded.
- REQ-029: abort in IDLE or COMMIT SHALL have no effect; commit in progress completes.
- REQ-030: start and abort both 1 in IDLE: SHALL remain IDLE.
- REQ-031: Shadow contents SHALL be irrelevant after abort; next load overwrites all TOTAL words.

Reset
- REQ-032: rst_n=0 SHALL immediately force IDLE, word counter 0, shadow 0, conf_out 0 (all switch muxes off), in_ready/fabric_hold/conf_en/done/busy 0.
- REQ-033: Reset mid-LOAD or mid-HOLD SHALL discard the load; no conf_en pulse.
- REQ-034: After rst_n deasserts, start SHALL be honored on the first rising edge.

Verification (NUM_SW=2, WPS=3, TOTAL=6)
- REQ-035: start; words 0x0001..0x0006 back-to-back; fabric_idle=1 -> conf_out = 0x0006_0005_0004_0003_0002_0001; conf_en/done one cycle; busy drops next cycle.
- REQ-036: Words with random in_valid gaps; fabric_idle held 0 for 10 cycles after last word -> fabric_hold=1 throughout, conf_out unchanged until cycle fabric_idle rises, then single conf_en.
- REQ-037: abort after 4 words accepted -> IDLE, conf_out retains prior value, no done; fresh load of 6 words then commits correctly.
- REQ-038: start asserted during LOAD and during HOLD -> ignored, word count continues; start+abort in IDLE -> stays IDLE, in_ready 0.
- REQ-039: rst_n pulsed low in HOLD with a prior committed config -> conf_out 0 asynchronously, all outputs 0, no conf_en.
- REQ-040: in_valid=1 in IDLE and COMMIT -> in_ready 0, no shadow change.

Source files
------------

// File: rtl/switch_conf_ctrl.sv
// Configuration load controller: streams WORD_W-bit words into a shadow image,
// holds the fabric until it drains, then swaps the image into conf_out atomically.
module switch_conf_ctrl #(
    parameter int NUM_SW    = 4,
    parameter int CONF_BITS = 48,
    parameter int WORD_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        in_valid,
    input  logic [WORD_W-1:0]           in_data,
    output logic                        in_ready,
    input  logic                        fabric_idle,
    output logic                        fabric_hold,
    output logic [NUM_SW*CONF_BITS-1:0] conf_out,
    output logic                        conf_en,
    output logic                        done,
    output logic                        busy
);

    localparam int WPS   = CONF_BITS / WORD_W;
    localparam int TOTAL = NUM_SW * WPS;
    localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD,
        COMMIT
    } state_t;

    state_t                       state;
    logic [CNT_W-1:0]             word_cnt;
    // Word n of the load lives at shadow[n], i.e. bits [n*WORD_W +: WORD_W].
    logic [TOTAL-1:0][WORD_W-1:0] shadow;
    logic                         accept;

    assign accept = in_valid & in_ready;

    // Outputs are registered alongside the state, so each branch sets them for
    // the state it is entering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every sequential assignment is non-blocking so all flops
            // sample the same pre-edge values regardless of statement order.
            state       <= IDLE;
            word_cnt    <= '0;
            // NOTE: the shadow image is explicitly reset; a reset must leave
            // no stale configuration anywhere that could later reach conf_out.
            shadow      <= '0;
            conf_out    <= '0;
            in_ready    <= 1'b0;
            fabric_hold <= 1'b0;
            conf_en     <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            conf_en <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state    <= LOAD;
                        word_cnt <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                LOAD: begin
                    if (abort) begin
                        // A word presented alongside abort is dropped.
                        state    <= IDLE;
                        word_cnt <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end else if (accept) begin
                        shadow[word_cnt] <= in_data;
                        if (word_cnt == LAST) begin
                            state       <= HOLD;
                            word_cnt    <= '0;
                            in_ready    <= 1'b0;
                            fabric_hold <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end

                HOLD: begin
                    // Abort wins over a simultaneous fabric_idle: nothing is committed.
                    if (abort) begin
                        state       <= IDLE;
                        word_cnt    <= '0;
                        fabric_hold <= 1'b0;
                        busy        <= 1'b0;
                    end else if (fabric_idle) begin
                        state    <= COMMIT;
                        conf_out <= shadow;
                        conf_en  <= 1'b1;
                        done     <= 1'b1;
                    end
                end

                COMMIT: begin
                    state       <= IDLE;
                    fabric_hold <= 1'b0;
                    busy        <= 1'b0;
                end

                default: begin
                    state       <= IDLE;
                    word_cnt    <= '0;
                    in_ready    <= 1'b0;
                    fabric_hold <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_conf_ctrl.sv
// Self-checking bench for switch_conf_ctrl with two switches of three 16-bit words.
// Expected values come from a word-list model of the committed configuration.
module tb_switch_conf_ctrl;

    localparam int NUM_SW    = 2;
    localparam int CONF_BITS = 48;
    localparam int WORD_W    = 16;
    localparam int TOTAL     = NUM_SW * (CONF_BITS / WORD_W);
    localparam int CW        = NUM_SW * CONF_BITS;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;
    logic              fabric_idle;
    logic              fabric_hold;
    logic [CW-1:0]     conf_out;
    logic              conf_en;
    logic              done;
    logic              busy;

    switch_conf_ctrl #(
        .NUM_SW   (NUM_SW),
        .CONF_BITS(CONF_BITS),
        .WORD_W   (WORD_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .fabric_idle(fabric_idle),
        .fabric_hold(fabric_hold),
        .conf_out   (conf_out),
        .conf_en    (conf_en),
        .done       (done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [CW-1:0]     model_conf;
    logic [WORD_W-1:0] cur [TOTAL];

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected configuration: word n occupies bits [n*WORD_W +: WORD_W].
    function automatic logic [CW-1:0] image_of_load();
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < TOTAL; i++) r[i*WORD_W +: WORD_W] = cur[i];
        return r;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  CW'(busy),        '0);
        check({tag, "_ready"}, CW'(in_ready),    '0);
        check({tag, "_hold"},  CW'(fabric_hold), '0);
        check({tag, "_en"},    CW'(conf_en),     '0);
        check({tag, "_done"},  CW'(done),        '0);
        check({tag, "_conf"},  conf_out,         model_conf);
    endtask

    task automatic start_load();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_ready", CW'(in_ready), CW'(1));
        check("load_busy",  CW'(busy),     CW'(1));
    endtask

    // Presents n random words, optionally with random idle gaps before each.
    task automatic feed(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_data  = WORD_W'($urandom);
                    tick();
                    check("gap_ready", CW'(in_ready), CW'(1));
                end
            end
            cur[i]   = WORD_W'($urandom);
            in_valid = 1'b1;
            in_data  = cur[i];
            tick();
            check("feed_ready", CW'(in_ready),    CW'(i + 1 < TOTAL));
            check("feed_hold",  CW'(fabric_hold), CW'(i + 1 == TOTAL));
            check("feed_conf",  conf_out,         model_conf);
        end
        in_valid = 1'b0;
    endtask

    task automatic hold_cycles(input int n);
        fabric_idle = 1'b0;
        repeat (n) begin
            tick();
            check("hold_hold",  CW'(fabric_hold), CW'(1));
            check("hold_ready", CW'(in_ready),    '0);
            check("hold_en",    CW'(conf_en),     '0);
            check("hold_conf",  conf_out,         model_conf);
        end
    endtask

    // Commit with in_valid held high to show words are refused in COMMIT and IDLE.
    task automatic commit();
        fabric_idle = 1'b1;
        in_valid    = 1'b1;
        in_data     = WORD_W'($urandom);
        tick();
        model_conf = image_of_load();
        check("commit_conf",  conf_out,         model_conf);
        check("commit_en",    CW'(conf_en),     CW'(1));
        check("commit_done",  CW'(done),        CW'(1));
        check("commit_ready", CW'(in_ready),    '0);
        check("commit_hold",  CW'(fabric_hold), CW'(1));
        tick();
        check_idle("post_commit");
        tick();
        check_idle("idle_valid");
        in_valid    = 1'b0;
        fabric_idle = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        fabric_idle = 1'b0;
        model_conf  = '0;

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check_idle("reset");
        tick();
        tick();
        rst_n = 1'b1;

        // Back-to-back known words, fabric already idle.
        start_load();
        fabric_idle = 1'b1;
        for (int i = 0; i < TOTAL; i++) begin
            cur[i]   = WORD_W'(i + 1);
            in_valid = 1'b1;
            in_data  = cur[i];
            tick();
        end
        in_valid = 1'b0;
        check("b2b_hold",  CW'(fabric_hold), CW'(1));
        check("b2b_ready", CW'(in_ready),    '0);
        commit();
        check("b2b_value", conf_out, 96'h0006_0005_0004_0003_0002_0001);

        // Random words with gaps, fabric busy for 10 cycles.
        start_load();
        feed(TOTAL, 1'b1);
        hold_cycles(10);
        commit();

        // Abort after four words; word presented with abort is discarded.
        start_load();
        feed(4, 1'b1);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = WORD_W'($urandom);
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        check_idle("abort_load");
        start_load();
        feed(TOTAL, 1'b0);
        commit();

        // Abort in HOLD wins over a simultaneous fabric_idle.
        start_load();
        feed(TOTAL, 1'b0);
        abort       = 1'b1;
        fabric_idle = 1'b1;
        tick();
        abort       = 1'b0;
        fabric_idle = 1'b0;
        check_idle("abort_hold");

        // start during LOAD and HOLD is ignored; the word count carries on.
        start_load();
        feed(3, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_load", CW'(in_ready), CW'(1));
        for (int i = 3; i < TOTAL; i++) begin
            cur[i]   = WORD_W'($urandom);
            in_valid = 1'b1;
            in_data  = cur[i];
            tick();
        end
        in_valid = 1'b0;
        check("count_cont_hold",  CW'(fabric_hold), CW'(1));
        check("count_cont_ready", CW'(in_ready),    '0);
        start = 1'b1;
        hold_cycles(2);
        start = 1'b0;
        commit();

        // start together with abort in IDLE stays idle.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_idle("start_abort");

        // Reset while holding a committed configuration.
        start_load();
        feed(TOTAL, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        model_conf = '0;
        check_idle("reset_hold");
        fabric_idle = 1'b1;
        tick();
        check_idle("reset_held");
        rst_n       = 1'b0;
        fabric_idle = 1'b0;
        rst_n       = 1'b1;
        start_load();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
